// File: rtl/axi_lite_pkg.sv
// Shared types for the two-requester AXI-lite arbiter: FSM states,
// default bus widths and the requester index type.
package axi_lite_pkg;

   localparam int ADDR_W_DEFAULT = 32;
   localparam int DATA_W_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   typedef logic req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: combinational choice, registered memory of the
// last winner, updated only when a grant is actually taken.
module rr_arbiter2
   import axi_lite_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic       any_req,
   output req_idx_t   grant
);

   req_idx_t last_grant_reg;

   always_comb begin
      any_req = |req;
      grant   = 1'b0;
      if (req[0] && req[1]) begin
         grant = ~last_grant_reg;
      end else if (req[1]) begin
         grant = 1'b1;
      end
   end

   // Resetting to 1 makes requester 0 the winner of the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_reg <= 1'b1;
      end else if (update) begin
         last_grant_reg <= grant;
      end
   end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI-lite slave port between two level-held command requesters,
// sequencing the full handshake and returning a one-cycle ack per command.
module axi_lite_arbiter
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEFAULT,
   parameter int DATA_W  = DATA_W_DEFAULT,
   parameter int TIMEOUT = 255
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_err,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_err,
   output logic              busy,
   output logic              awvalid,
   output logic [ADDR_W-1:0] awaddr,
   input  logic              awready,
   output logic              wvalid,
   output logic [DATA_W-1:0] wdata,
   input  logic              wready,
   input  logic              bvalid,
   output logic              bready,
   output logic              arvalid,
   output logic [ADDR_W-1:0] araddr,
   input  logic              arready,
   input  logic              rvalid,
   input  logic [DATA_W-1:0] rdata,
   output logic              rready
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   logic [1:0]        req_vec, we_vec;
   logic [ADDR_W-1:0] addr_vec  [2];
   logic [DATA_W-1:0] wdata_vec [2];

   assign req_vec      = {r1_req, r0_req};
   assign we_vec       = {r1_we, r0_we};
   assign addr_vec[0]  = r0_addr;
   assign addr_vec[1]  = r1_addr;
   assign wdata_vec[0] = r0_wdata;
   assign wdata_vec[1] = r1_wdata;

   state_t            state_reg, state_next;
   req_idx_t          gnt_reg, gnt_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              awvalid_reg, awvalid_next, wvalid_reg, wvalid_next;
   logic              bready_reg, bready_next, arvalid_reg, arvalid_next;
   logic              rready_reg, rready_next, busy_reg, busy_next;
   logic [ADDR_W-1:0] awaddr_reg, awaddr_next, araddr_reg, araddr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;

   logic              arb_any, arb_update, timeout, wait_state;
   req_idx_t          arb_grant;
   logic              fin, fin_err;
   logic [DATA_W-1:0] fin_rdata;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_vec),
      .update  (arb_update),
      .any_req (arb_any),
      .grant   (arb_grant)
   );

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      awvalid_next = awvalid_reg;
      wvalid_next  = wvalid_reg;
      arvalid_next = arvalid_reg;
      bready_next  = 1'b0;
      rready_next  = 1'b0;
      awaddr_next  = awaddr_reg;
      araddr_next  = araddr_reg;
      wdata_next   = wdata_reg;
      arb_update   = 1'b0;
      fin          = 1'b0;
      fin_err      = 1'b0;
      fin_rdata    = '0;
      timeout      = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

      case (state_reg)
         IDLE: begin
            if (arb_any) begin
               arb_update = 1'b1;
               gnt_next   = arb_grant;
               if (we_vec[arb_grant]) begin
                  awaddr_next  = addr_vec[arb_grant];
                  wdata_next   = wdata_vec[arb_grant];
                  awvalid_next = 1'b1;
                  wvalid_next  = 1'b1;
                  state_next   = WR;
               end else begin
                  araddr_next  = addr_vec[arb_grant];
                  arvalid_next = 1'b1;
                  state_next   = RD_ADDR;
               end
            end
         end
         WR: begin
            // Address and data channels retire independently.
            if (awvalid_reg && awready) awvalid_next = 1'b0;
            if (wvalid_reg && wready)   wvalid_next  = 1'b0;
            if (!awvalid_next && !wvalid_next) begin
               bready_next = 1'b1;
               state_next  = WR_RESP;
            end else if (timeout) begin
               awvalid_next = 1'b0;
               wvalid_next  = 1'b0;
               fin          = 1'b1;
               fin_err      = 1'b1;
               state_next   = DONE;
            end
         end
         WR_RESP: begin
            if (bvalid) begin
               fin        = 1'b1;
               state_next = DONE;
            end else if (timeout) begin
               fin        = 1'b1;
               fin_err    = 1'b1;
               state_next = DONE;
            end else begin
               bready_next = 1'b1;
            end
         end
         RD_ADDR: begin
            if (arready) begin
               arvalid_next = 1'b0;
               rready_next  = 1'b1;
               state_next   = RD_DATA;
            end else if (timeout) begin
               arvalid_next = 1'b0;
               fin          = 1'b1;
               fin_err      = 1'b1;
               state_next   = DONE;
            end
         end
         RD_DATA: begin
            if (rvalid) begin
               fin        = 1'b1;
               fin_rdata  = rdata;
               state_next = DONE;
            end else if (timeout) begin
               fin        = 1'b1;
               fin_err    = 1'b1;
               state_next = DONE;
            end else begin
               rready_next = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      busy_next  = (state_next != IDLE);
      wait_state = (state_reg == WR) || (state_reg == WR_RESP) ||
                   (state_reg == RD_ADDR) || (state_reg == RD_DATA);
      // Counter restarts on every state entry so each wait phase gets a full budget.
      cnt_next   = ((state_next != state_reg) || !wait_state) ? '0 : cnt_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         gnt_reg     <= 1'b0;
         cnt_reg     <= '0;
         awvalid_reg <= 1'b0;
         wvalid_reg  <= 1'b0;
         bready_reg  <= 1'b0;
         arvalid_reg <= 1'b0;
         rready_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         awaddr_reg  <= '0;
         araddr_reg  <= '0;
         wdata_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         cnt_reg     <= cnt_next;
         awvalid_reg <= awvalid_next;
         wvalid_reg  <= wvalid_next;
         bready_reg  <= bready_next;
         arvalid_reg <= arvalid_next;
         rready_reg  <= rready_next;
         busy_reg    <= busy_next;
         awaddr_reg  <= awaddr_next;
         araddr_reg  <= araddr_next;
         wdata_reg   <= wdata_next;
      end
   end

   logic [1:0]        ack_vec, err_vec;
   logic [DATA_W-1:0] rdata_vec [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic              ack_reg, err_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
         end else if (fin && (gnt_reg == req_idx_t'(gi))) begin
            ack_reg   <= 1'b1;
            err_reg   <= fin_err;
            rdata_reg <= fin_rdata;
         end else begin
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
         end
      end

      assign ack_vec[gi]   = ack_reg;
      assign err_vec[gi]   = err_reg;
      assign rdata_vec[gi] = rdata_reg;
   end

   assign r0_ack   = ack_vec[0];
   assign r1_ack   = ack_vec[1];
   assign r0_err   = err_vec[0];
   assign r1_err   = err_vec[1];
   assign r0_rdata = rdata_vec[0];
   assign r1_rdata = rdata_vec[1];
   assign busy     = busy_reg;
   assign awvalid  = awvalid_reg;
   assign awaddr   = awaddr_reg;
   assign wvalid   = wvalid_reg;
   assign wdata    = wdata_reg;
   assign bready   = bready_reg;
   assign arvalid  = arvalid_reg;
   assign araddr   = araddr_reg;
   assign rready   = rready_reg;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: negedge-driven AXI-lite slave model
// and an ack scoreboard filled as commands are issued.
module tb_axi_lite_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk, rst_n;
   logic          r0_req, r0_we, r1_req, r1_we;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [DW-1:0] r0_wdata, r1_wdata;
   logic          r0_ack, r0_err, r1_ack, r1_err, busy;
   logic [DW-1:0] r0_rdata, r1_rdata;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [DW-1:0] rdata;

   axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
      .busy(busy),
      .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wready(wready),
      .bvalid(bvalid), .bready(bready),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rready(rready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Slave model: decides at negedge what handshakes the next posedge will complete.
   int            aw_delay;
   bit            r_never, b_hold, slave_rst;
   bit            have_aw, have_w, have_ar, aw_go, w_go, ar_go, b_go, r_go;
   int            aw_seen;
   logic [AW-1:0] aw_addr_l, ar_addr_l;
   logic [DW-1:0] w_data_l;
   logic [DW-1:0] mem [16] = '{default: '0};

   always @(negedge clk) begin
      if (slave_rst) begin
         awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0;
         have_aw = 0; have_w = 0; have_ar = 0; aw_go = 0; w_go = 0; ar_go = 0;
         b_go = 0; r_go = 0; aw_seen = 0; aw_addr_l = '0; ar_addr_l = '0; w_data_l = '0;
      end else begin
         if (aw_go) begin have_aw = 1; aw_go = 0; end
         if (w_go)  begin have_w  = 1; w_go  = 0; end
         if (ar_go) begin have_ar = 1; ar_go = 0; end
         if (b_go)  begin bvalid  = 0; b_go  = 0; end
         if (r_go)  begin rvalid  = 0; r_go  = 0; end
         if (have_aw && have_w && !bvalid && !b_hold) begin
            mem[aw_addr_l[5:2]] = w_data_l;
            bvalid = 1; have_aw = 0; have_w = 0;
         end
         if (bvalid && bready) b_go = 1;
         if (awvalid && !have_aw && !aw_go) begin
            awready = (aw_seen >= aw_delay);
            aw_seen++;
            if (awready) begin aw_go = 1; aw_addr_l = awaddr; aw_seen = 0; end
         end else begin
            awready = 0; aw_seen = 0;
         end
         wready = wvalid && !have_w && !w_go;
         if (wready) begin w_go = 1; w_data_l = wdata; end
         arready = arvalid && !have_ar && !ar_go;
         if (arready) begin ar_go = 1; ar_addr_l = araddr; end
         if (have_ar && !rvalid && !r_never) begin
            rvalid = 1; rdata = mem[ar_addr_l[5:2]]; have_ar = 0;
         end
         if (rvalid && rready) r_go = 1;
      end
   end

   int ack_total = 0;
   always @(negedge clk) ack_total += int'(r0_ack) + int'(r1_ack);

   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic        err;
      bit          chk_rd;
   } exp_t;

   exp_t sb[$];
   int   errors, checks, n_pushed;
   int   n_aw, n_w, n_b, n_r;
   int   lat, who, rem0, rem1, acks_before;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input int idx, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      if (idx == 0) begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wd; end
      else          begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wd; end
   endtask

   task automatic expect_ack(input int idx, input logic [31:0] rd, input logic err, input bit chk);
      exp_t e;
      e.idx = idx; e.rdata = rd; e.err = err; e.chk_rd = chk;
      sb.push_back(e);
      n_pushed++;
   endtask

   task automatic pop_and_check(output int w);
      exp_t e;
      w = r1_ack ? 1 : 0;
      check("ack_onehot", 64'(r0_ack & r1_ack), 64'(0));
      check("sb_nonempty", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
         e = sb.pop_front();
         $display("txn: ack r%0d err=%0b rdata=%08h (expected r%0d err=%0b rdata=%08h)",
                  w, w ? r1_err : r0_err, w ? r1_rdata : r0_rdata, e.idx, e.err, e.rdata);
         check("ack_who", 64'(w), 64'(e.idx));
         check("ack_err", 64'(w ? r1_err : r0_err), 64'(e.err));
         if (e.chk_rd) check("ack_rdata", 64'(w ? r1_rdata : r0_rdata), 64'(e.rdata));
      end
   endtask

   task automatic watch(input int budget, output int l, output int w);
      bit got;
      got = 0; l = 0; w = -1;
      n_aw = 0; n_w = 0; n_b = 0; n_r = 0;
      while (!got && l < budget) begin
         tick();
         l++;
         n_aw += int'(awvalid); n_w += int'(wvalid);
         n_b  += int'(bready);  n_r += int'(rready);
         if (r0_ack || r1_ack) got = 1;
      end
      check("ack_arrived", 64'(got), 64'(1));
      if (got) pop_and_check(w);
   endtask

   initial begin
      errors = 0; checks = 0; n_pushed = 0;
      slave_rst = 1; aw_delay = 0; r_never = 0; b_hold = 0;
      rst_n = 0;
      r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
      r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
      repeat (3) tick();

      check("rst_busy",    64'(busy), 64'(0));
      check("rst_valids",  64'({awvalid, wvalid, arvalid}), 64'(0));
      check("rst_readies", 64'({bready, rready}), 64'(0));
      check("rst_acks",    64'({r0_ack, r1_ack, r0_err, r1_err}), 64'(0));
      check("rst_addr",    64'({awaddr, araddr}), 64'(0));
      check("rst_wdata",   64'(wdata), 64'(0));
      check("rst_rdata",   64'({r0_rdata, r1_rdata}), 64'(0));

      rst_n = 1; slave_rst = 0;
      tick();

      // Both requesters held: r0 wins the first tie, then strict alternation.
      cmd(0, 1'b1, 32'h4, 32'h11);
      cmd(1, 1'b0, 32'h4, 32'h0);
      expect_ack(0, 32'h0, 1'b0, 1'b0);
      expect_ack(1, 32'h11, 1'b0, 1'b1);
      expect_ack(0, 32'h0, 1'b0, 1'b0);
      expect_ack(1, 32'h11, 1'b0, 1'b1);
      rem0 = 2; rem1 = 2;
      for (int i = 0; i < 4; i++) begin
         watch(20, lat, who);
         check("rr_lat", 64'(lat), 64'((i == 0) ? 3 : 4));
         if (who == 0) begin rem0--; if (rem0 == 0) r0_req = 0; end
         else if (who == 1) begin rem1--; if (rem1 == 0) r1_req = 0; end
      end
      tick();
      check("rr_idle_busy", 64'(busy), 64'(0));

      // Zero-wait write.
      cmd(0, 1'b1, 32'h0, 32'hDEADBEEF);
      expect_ack(0, 32'h0, 1'b0, 1'b0);
      tick();
      check("wr_valids", 64'({awvalid, wvalid}), 64'(2'b11));
      check("wr_awaddr", 64'(awaddr), 64'(0));
      check("wr_wdata",  64'(wdata), 64'(32'hDEADBEEF));
      check("wr_busy",   64'(busy), 64'(1));
      watch(20, lat, who);
      check("wr_lat", 64'(lat + 1), 64'(3));
      check("wr_bready_cycles", 64'(n_b), 64'(1));
      r0_req = 0;
      tick();
      check("wr_ack_pulse", 64'(r0_ack), 64'(0));
      check("wr_idle_busy", 64'(busy), 64'(0));

      // Read back the written word.
      cmd(0, 1'b0, 32'h0, 32'h0);
      expect_ack(0, 32'hDEADBEEF, 1'b0, 1'b1);
      watch(20, lat, who);
      check("rd_lat", 64'(lat), 64'(3));
      r0_req = 0;
      tick();

      // awready three cycles late, wready immediate.
      aw_delay = 3;
      cmd(0, 1'b1, 32'h8, 32'h55);
      expect_ack(0, 32'h0, 1'b0, 1'b0);
      watch(30, lat, who);
      check("slow_aw_cycles", 64'(n_aw), 64'(4));
      check("slow_w_cycles",  64'(n_w), 64'(1));
      check("slow_b_cycles",  64'(n_b), 64'(1));
      check("slow_lat",       64'(lat), 64'(6));
      r0_req = 0; aw_delay = 0;
      tick();

      // Read timeout: rvalid never arrives.
      r_never = 1;
      cmd(1, 1'b0, 32'h4, 32'h0);
      expect_ack(1, 32'h0, 1'b1, 1'b1);
      watch(40, lat, who);
      check("to_lat", 64'(lat), 64'(10));
      check("to_rready_cycles", 64'(n_r), 64'(TO));
      check("to_rready_drop", 64'(rready), 64'(0));
      r1_req = 0;
      tick();
      check("to_idle_busy", 64'(busy), 64'(0));
      slave_rst = 1; r_never = 0;
      tick();
      slave_rst = 0;
      cmd(0, 1'b1, 32'hC, 32'h77);
      expect_ack(0, 32'h0, 1'b0, 1'b0);
      watch(20, lat, who);
      check("post_to_lat", 64'(lat), 64'(3));
      r0_req = 0;
      tick();

      // Asynchronous reset while waiting for the write response.
      b_hold = 1;
      cmd(0, 1'b1, 32'h10, 32'h99);
      tick();
      tick();
      check("rst_pre_bready", 64'(bready), 64'(1));
      #2 rst_n = 0;
      #1;
      check("arst_busy",   64'(busy), 64'(0));
      check("arst_ready",  64'({bready, rready}), 64'(0));
      check("arst_valids", 64'({awvalid, wvalid, arvalid}), 64'(0));
      check("arst_awaddr", 64'(awaddr), 64'(0));
      check("arst_wdata",  64'(wdata), 64'(0));
      check("arst_ack",    64'({r0_ack, r1_ack}), 64'(0));
      r0_req = 0;
      acks_before = ack_total;
      repeat (2) tick();
      rst_n = 1; slave_rst = 1; b_hold = 0;
      tick();
      slave_rst = 0;
      check("arst_no_ack", 64'(ack_total), 64'(acks_before));
      cmd(0, 1'b0, 32'h4, 32'h0);
      expect_ack(0, 32'h11, 1'b0, 1'b1);
      watch(20, lat, who);
      check("arst_rd_lat", 64'(lat), 64'(3));
      r0_req = 0;
      tick();

      check("sb_empty",  64'(sb.size()), 64'(0));
      check("ack_total", 64'(ack_total), 64'(n_pushed));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-requester arbiter and sequencer that shares one AXI-lite slave port (`axi_lite_slave`) between two internal masters. Each requester issues a simple level-held command (read or write). The arbiter grants round-robin and runs the full AXI-lite address/data/response handshake on the shared port. It returns a one-cycle acknowledge with read data or a timeout error. It sits between the peripheral's internal clients and the slave's AXI-lite interface.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 255, max cycles waiting in any slave-wait state before abort; 0 disables.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rN_req`  in  1  (N=0,1) command request; held high until `rN_ack`.
- `rN_we`  in  1  1 = write, 0 = read; stable while `rN_req`.
- `rN_addr`  in  ADDR_W  command address; stable while `rN_req`.
- `rN_wdata`  in  DATA_W  write data; stable while `rN_req`.
- `rN_ack`  out  1  one-cycle completion pulse.
- `rN_rdata`  out  DATA_W  read data, valid when `rN_ack` and `!rN_we`; holds until next ack to same requester.
- `rN_err`  out  1  timeout abort flag, valid with `rN_ack`.
- `busy`  out  1  high in every state except IDLE.
- `awvalid`/`awaddr`/`awready`, `wvalid`/`wdata`/`wready`, `bvalid`/`bready`, `arvalid`/`araddr`/`arready`, `rvalid`/`rdata`/`rready`  — AXI-lite master side; valids, readies-out, addr, and wdata are outputs; slave readies, `bvalid`, `rvalid`, and `rdata` are inputs; widths per ADDR_W/DATA_W.

## Operation
- States: IDLE, WR (addr+data phase), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: if any `req`, grant one requester and latch its we/addr/wdata. Then go to WR, or to RD_ADDR.
- Round-robin: a single request wins. If both request, grant the one not granted last. `last_grant` resets to 1, so r0 wins the first tie.
- WR: `awvalid` and `wvalid` assert together. Each deasserts independently in the cycle after its own handshake (`valid & ready`). When both have completed, go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, go to DONE.
- RD_ADDR: `arvalid`=1. On `arready`, go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, capture `rdata` and go to DONE.
- DONE: pulse `rN_ack` for the granted requester, drive `rN_rdata`/`rN_err`, return to IDLE. A requester drops `req` on the ack edge.
- Timeout counter clears on every state entry and counts in WR, WR_RESP, RD_ADDR, and RD_DATA. On reaching TIMEOUT: drop all valids/readies, set err=1, capture rdata=0, go to DONE.
  - After an abort the slave state is undefined. Recovery is the system's responsibility.
- `bready`/`rready` are high only in WR_RESP/RD_DATA. The write-response code is ignored; the slave has no resp field.

## Timing
- All outputs are registered.
- Reset values: all valids/readies 0, `awaddr`/`araddr`/`wdata` 0, `rN_ack`/`rN_err` 0, `rN_rdata` 0, `busy` 0, state IDLE, counter 0, `last_grant` 1.
- Latency: `req` sampled in IDLE → AXI valid high the next cycle. A zero-wait write completes with ack 4 cycles after req (IDLE, WR, WR_RESP, DONE). Reads behave the same (IDLE, RD_ADDR, RD_DATA, DONE).
- At least one IDLE cycle separates transactions. Back-to-back throughput is 1 transaction per 4 cycles minimum.
- A simultaneous awready and wready in the same cycle moves WR→WR_RESP next cycle.
- A `req` that drops before ack is a protocol violation; the transaction still completes and acks.
- `rst_n` asserted mid-transaction forces all outputs to reset values immediately (asynchronously). No ack is issued.

## Structure
- Shared package `axi_lite_pkg`: state enum, ADDR_W/DATA_W defaults, requester-index type.
- Sub-module `rr_arbiter2`: combinational grant from two reqs plus registered `last_grant`, with an update strobe from IDLE→active.
- The FSM, latch registers, and timeout counter live in the top level.

## Test plan
- r0 writes 0x0 ← 0xDEADBEEF with an always-ready slave → awvalid/wvalid high 1 cycle after req, bready handshake, r0_ack 4 cycles after req, r0_err=0.
- r0 reads 0x0 after that write → r0_ack with r0_rdata=0xDEADBEEF, r0_err=0.
- r0 (write 0x4←0x11) and r1 (read 0x4) both held from reset, re-requesting after each ack → grant order r0,r1,r0,r1; r1 reads 0x11.
- Slave model asserts wready immediately and awready 3 cycles later → wvalid low after 1 cycle, awvalid held 4 cycles, then one bready phase, single ack.
- TIMEOUT=8, slave never asserts rvalid → r1_ack with r1_err=1 and r1_rdata=0, 8 cycles after RD_DATA entry; busy then low; a following r0 write succeeds.
- Drop rst_n during WR_RESP → all outputs to reset values in the same cycle, no ack. After release, a new r0 read is granted normally.
